// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-LED PWM dimmer with optional linear fade, controlled over Avalon-MM.
// Build option: define LED_PWM_STATUS_EN to expose the STATUS register at address 3.
module led_pwm_fader #(
    parameter int DW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW:0]   led_in,
    input  logic [1:0]    address,
    input  logic          chipselect,
    input  logic          read,
    input  logic          write,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic [DW:0]   LEDG
);

    localparam int N = DW + 1;

    logic [DW:0]       led_q, led_d;
    logic              ctrl_en_q, ctrl_en_d;
    logic              ctrl_fade_q, ctrl_fade_d;
    logic [7:0]        bright_q, bright_d;
    logic [15:0]       prescale_q, prescale_d;
    logic [15:0]       presc_cnt_q, presc_cnt_d;
    logic [7:0]        pwm_cnt_q, pwm_cnt_d;
    logic [DW:0][7:0]  duty_q, duty_d;
    logic [31:0]       readdata_q, readdata_d;

    logic [DW:0][7:0]  target;
    logic              tick;
    logic              period_end;
    logic [31:0]       status_word;

    // Reads update on chipselect alone; read strobe and upper write bits carry no information here.
    logic unused_ok;
    assign unused_ok = &{1'b0, read, writedata[31:16]};

    always_comb begin
        led_d = led_in;
        for (int i = 0; i < N; i++) begin
            target[i] = led_q[i] ? bright_q : 8'h00;
        end
    end

    always_comb begin
        tick        = ctrl_en_q && (presc_cnt_q == prescale_q);
        period_end  = tick && (pwm_cnt_q == 8'hFF);
        presc_cnt_d = presc_cnt_q + 16'd1;
        pwm_cnt_d   = pwm_cnt_q;
        if (!ctrl_en_q) begin
            presc_cnt_d = 16'd0;
            pwm_cnt_d   = 8'd0;
        end else if (tick) begin
            presc_cnt_d = 16'd0;
            pwm_cnt_d   = pwm_cnt_q + 8'd1;
        end
    end

    // Fading steps one count per PWM period, so a retarget simply reverses the ramp.
    always_comb begin
        duty_d = duty_q;
        for (int i = 0; i < N; i++) begin
            if (!ctrl_en_q) begin
                duty_d[i] = 8'd0;
            end else if (!ctrl_fade_q) begin
                duty_d[i] = target[i];
            end else if (period_end) begin
                if (duty_q[i] < target[i]) begin
                    duty_d[i] = duty_q[i] + 8'd1;
                end else if (duty_q[i] > target[i]) begin
                    duty_d[i] = duty_q[i] - 8'd1;
                end
            end
        end
    end

    always_comb begin
        ctrl_en_d   = ctrl_en_q;
        ctrl_fade_d = ctrl_fade_q;
        bright_d    = bright_q;
        prescale_d  = prescale_q;
        if (chipselect && write) begin
            case (address)
                2'd0: begin
                    ctrl_en_d   = writedata[0];
                    ctrl_fade_d = writedata[1];
                end
                2'd1:    bright_d   = writedata[7:0];
                2'd2:    prescale_d = writedata[15:0];
                default: ;
            endcase
        end
    end

`ifdef LED_PWM_STATUS_EN
    logic fade_active;

    always_comb begin
        fade_active = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (duty_q[i] != target[i]) begin
                fade_active = 1'b1;
            end
        end
    end

    assign status_word = {7'b0, fade_active, 8'b0, pwm_cnt_q, duty_q[0]};
`else
    assign status_word = 32'h0000_0000;
`endif

    always_comb begin
        readdata_d = readdata_q;
        if (chipselect) begin
            case (address)
                2'd0:    readdata_d = {30'b0, ctrl_fade_q, ctrl_en_q};
                2'd1:    readdata_d = {24'b0, bright_q};
                2'd2:    readdata_d = {16'b0, prescale_q};
                default: readdata_d = status_word;
            endcase
        end
    end

    always_comb begin
        LEDG = '0;
        for (int i = 0; i < N; i++) begin
            LEDG[i] = ctrl_en_q && (pwm_cnt_q < duty_q[i]);
        end
    end

    assign readdata = readdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            led_q       <= '0;
            ctrl_en_q   <= 1'b1;
            ctrl_fade_q <= 1'b0;
            bright_q    <= 8'hFF;
            prescale_q  <= 16'd0;
            presc_cnt_q <= 16'd0;
            pwm_cnt_q   <= 8'd0;
            duty_q      <= '0;
            readdata_q  <= 32'd0;
        end else begin
            led_q       <= led_d;
            ctrl_en_q   <= ctrl_en_d;
            ctrl_fade_q <= ctrl_fade_d;
            bright_q    <= bright_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_q      <= duty_d;
            readdata_q  <= readdata_d;
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader: directed steps plus random traffic against a cycle model.
module tb_led_pwm_fader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  led_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  LEDG;

    always #5 clk = ~clk;

    led_pwm_fader #(.DW(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .led_in     (led_in),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .LEDG       (LEDG)
    );

`ifdef LED_PWM_STATUS_EN
    localparam logic [31:0] ST5 = 32'h0100_0005;
`else
    localparam logic [31:0] ST5 = 32'h0000_0000;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: register file, phase counters and per-LED duty as plain integers.
    int          m_led, m_en, m_fade, m_bright, m_presc, m_pc, m_pwm;
    int          m_duty[8];
    logic [31:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_led = 0; m_en = 1; m_fade = 0; m_bright = 255; m_presc = 0;
        m_pc = 0; m_pwm = 0; m_rd = 32'd0;
        for (int i = 0; i < 8; i++) m_duty[i] = 0;
    endtask

    task automatic model_step();
        int          tgt[8];
        int          nd[8];
        bit          tick, pend, act;
        logic [31:0] rdv;
        tick = (m_en != 0) && (m_pc == m_presc);
        pend = tick && (m_pwm == 255);
        act  = 0;
        for (int i = 0; i < 8; i++) begin
            tgt[i] = ((m_led >> i) & 1) != 0 ? m_bright : 0;
            if (m_duty[i] != tgt[i]) act = 1;
            if (m_en == 0)                          nd[i] = 0;
            else if (m_fade == 0)                   nd[i] = tgt[i];
            else if (pend && m_duty[i] < tgt[i])    nd[i] = m_duty[i] + 1;
            else if (pend && m_duty[i] > tgt[i])    nd[i] = m_duty[i] - 1;
            else                                    nd[i] = m_duty[i];
        end
        rdv = m_rd;
        if (chipselect) begin
            case (address)
                2'd0: rdv = m_en + 2 * m_fade;
                2'd1: rdv = m_bright;
                2'd2: rdv = m_presc;
`ifdef LED_PWM_STATUS_EN
                default: rdv = (act ? 32'h0100_0000 : 32'h0) + m_pwm * 256 + m_duty[0];
`else
                default: rdv = 32'd0;
`endif
            endcase
        end
        if (!reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 8; i++) m_duty[i] = nd[i];
        if (m_en == 0) begin
            m_pc = 0; m_pwm = 0;
        end else if (tick) begin
            m_pc = 0; m_pwm = (m_pwm + 1) % 256;
        end else begin
            m_pc = (m_pc + 1) % 65536;
        end
        m_rd  = rdv;
        m_led = led_in;
        if (chipselect && write) begin
            case (address)
                2'd0: begin m_en = writedata[0]; m_fade = writedata[1]; end
                2'd1: m_bright = writedata[7:0];
                2'd2: m_presc  = writedata[15:0];
                default: ;
            endcase
        end
    endtask

    function automatic logic [7:0] exp_ledg();
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++)
            if (m_en != 0 && m_pwm < m_duty[i]) e[i] = 1'b1;
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("ledg", {24'b0, LEDG}, {24'b0, exp_ledg()});
        chk("readdata", readdata, m_rd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        cyc();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        chipselect = 1'b1; read = 1'b1; address = a;
        cyc();
        chipselect = 1'b0; read = 1'b0;
        chk(tag, readdata, exp);
    endtask

    // Counts LEDG[0] over one 256-sample window; optionally reads STATUS on its first cycle.
    task automatic period_count(input bit st, output int c);
        c = 0;
        for (int i = 0; i < 256; i++) begin
            if (LEDG[0]) c++;
            if (st && i == 0) begin
                chipselect = 1'b1; read = 1'b1; address = 2'd3;
                cyc();
                chipselect = 1'b0; read = 1'b0;
            end else begin
                cyc();
            end
        end
    endtask

    task automatic wait_pwm0();
        int n;
        n = 0;
        while (m_pwm != 0 && n < 400) begin cyc(); n++; end
    endtask

    int c, n, hi, lo, r, c_hi;

    initial begin
        model_reset();
        reset = 1'b0; led_in = 8'hFF; address = 2'd0;
        chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = 32'd0;

        repeat (2) cyc();
        chk("rst_ledg", {24'b0, LEDG}, 32'h0);
        chk("rst_rdata", readdata, 32'h0);

        reset = 1'b1;
        repeat (2) cyc();
        c = 0;
        for (int i = 0; i < 256; i++) begin
            if (LEDG == 8'hFF) c++;
            cyc();
        end
        chk("full_bright_on", c, 255);

        rd(2'd0, 32'h1,  "rb_ctrl");
        rd(2'd1, 32'hFF, "rb_bright");
        rd(2'd2, 32'h0,  "rb_presc");

        led_in = 8'h01;
        wr(2'd1, 32'h40);
        repeat (3) cyc();
        c = 0; c_hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (LEDG[0]) c++;
            if (LEDG[7:1] != 7'd0) c_hi++;
            cyc();
        end
        chk("bright40_on", c, 64);
        chk("bright40_others", c_hi, 0);

        wr(2'd2, 32'd3);
        n = 0;
        while (LEDG[0] && n < 3000) begin cyc(); n++; end
        while (!LEDG[0] && n < 3000) begin cyc(); n++; end
        hi = 0;
        while (LEDG[0] && hi < 3000) begin cyc(); hi++; end
        lo = 0;
        while (!LEDG[0] && lo < 3000) begin cyc(); lo++; end
        chk("presc_high", hi, 256);
        chk("presc_period", hi + lo, 1024);

        chk("pre_disable_on", {31'b0, LEDG[0]}, 32'h1);
        wr(2'd0, 32'h0);
        chk("disable_ledg", {24'b0, LEDG}, 32'h0);
        rd(2'd0, 32'h0, "rb_ctrl_off");
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h1);
        period_count(1'b0, c);
        chk("restart_p0", c, 63);
        period_count(1'b0, c);
        chk("restart_p1", c, 64);

        led_in = 8'h00;
        wr(2'd1, 32'h10);
        repeat (3) cyc();
        wr(2'd0, 32'h3);
        wait_pwm0();
        led_in = 8'h01;
        for (int k = 0; k < 18; k++) begin
            period_count(k == 5, c);
            chk("fade_up", c, (k < 16) ? k : 16);
            if (k == 5) chk("status_mid_fade", readdata, ST5);
        end
        led_in = 8'h00;
        for (int j = 0; j <= 16; j++) begin
            period_count(1'b0, c);
            chk("fade_down", c, 16 - j);
        end
        led_in = 8'h01;
        for (int k = 0; k <= 16; k++) begin
            if (k == 8) led_in = 8'h00;
            period_count(1'b0, c);
            chk("fade_reverse", c, (k <= 8) ? k : 16 - k);
        end

        led_in = 8'h01;
        for (int k = 0; k < 3; k++) begin
            period_count(1'b0, c);
            chk("fade_pre_reset", c, k);
        end
        chk("pre_reset_on", {31'b0, LEDG[0]}, 32'h1);
        reset = 1'b0;
        cyc();
        chk("reset_mid_fade_ledg", {24'b0, LEDG}, 32'h0);
        chk("reset_mid_fade_rdata", readdata, 32'h0);
        reset = 1'b1;

        for (int it = 0; it < 1500; it++) begin
            r = $urandom_range(0, 15);
            case (r)
                0: wr(2'd1, $urandom);
                1: wr(2'd0, 32'($urandom_range(1, 3)));
                2: begin
                    wr(2'd0, 32'h0);
                    wr(2'd2, 32'($urandom_range(0, 2)));
                    wr(2'd0, 32'($urandom_range(1, 3)));
                end
                3, 4: begin led_in = 8'($urandom); cyc(); end
                5: begin
                    chipselect = 1'b1; read = 1'($urandom_range(0, 1));
                    address = 2'($urandom_range(0, 3));
                    cyc();
                    chipselect = 1'b0; read = 1'b0;
                end
                6: wr(2'd3, $urandom);
                7: begin
                    if ($urandom_range(0, 9) == 0) reset = 1'b0;
                    cyc();
                    reset = 1'b1;
                end
                default: cyc();
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
